// File: rtl/wrapper_frame_sink.sv
// Clock_2-domain frame sink: packs valid words into FRAME_LEN-word frames with a running sum.
// Optional `SINK_SEQ_CHECK_EN builds an incrementing-sequence checker driving seq_error.
module wrapper_frame_sink #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 24,
  parameter int IDLE_TMO  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_2_valid,
  input  logic [DATA_W-1:0] data_2,
  input  logic              buffer_empty,
  input  logic              frame_ack,
  output logic              frame_ready,
  output logic [SUM_W-1:0]  frame_sum,
  output logic [7:0]        frame_len,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic              seq_error
);

  localparam int TMO_W = $clog2(IDLE_TMO + 1);
  localparam logic [7:0]       LEN_FULL = 8'(FRAME_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TMO);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic [SUM_W-1:0] acc, acc_nxt, sum_nxt, acc_plus;
  logic [7:0]       cnt, cnt_nxt, len_nxt, cnt_plus;
  logic [TMO_W-1:0] idle_cnt, idle_nxt, idle_plus;
  logic [15:0]      fcount_nxt, drop_nxt;
  logic [SUM_W-1:0] word_ext;
  logic             accept;

  assign word_ext  = SUM_W'(data_2);
  assign acc_plus  = acc + word_ext;
  assign cnt_plus  = cnt + 8'd1;
  assign idle_plus = idle_cnt + TMO_ONE;
  assign accept    = data_2_valid && (state != S_HOLD);

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    idle_nxt   = idle_cnt;
    sum_nxt    = frame_sum;
    len_nxt    = frame_len;
    fcount_nxt = frame_count;
    drop_nxt   = drop_count;
    case (state)
      S_IDLE: begin
        if (data_2_valid) begin
          acc_nxt   = word_ext;
          cnt_nxt   = 8'd1;
          idle_nxt  = '0;
          state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (data_2_valid) begin
          acc_nxt  = acc_plus;
          cnt_nxt  = cnt_plus;
          idle_nxt = '0;
          if (cnt_plus == LEN_FULL) begin
            sum_nxt   = acc_plus;
            len_nxt   = LEN_FULL;
            state_nxt = S_HOLD;
          end
        end else if (buffer_empty) begin
          // Timeout closes the partial frame with whatever has been collected.
          if (idle_plus == TMO_LAST) begin
            sum_nxt   = acc;
            len_nxt   = cnt;
            idle_nxt  = '0;
            state_nxt = S_HOLD;
          end else begin
            idle_nxt = idle_plus;
          end
        end else begin
          idle_nxt = '0;
        end
      end
      S_HOLD: begin
        if (data_2_valid && (drop_count != '1)) drop_nxt = drop_count + 16'd1;
        if (frame_ack) begin
          fcount_nxt = frame_count + 16'd1;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      idle_cnt    <= '0;
      frame_sum   <= '0;
      frame_len   <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      idle_cnt    <= idle_nxt;
      frame_sum   <= sum_nxt;
      frame_len   <= len_nxt;
      frame_count <= fcount_nxt;
      drop_count  <= drop_nxt;
    end
  end

  assign frame_ready = (state == S_HOLD);

`ifdef SINK_SEQ_CHECK_EN
  logic [DATA_W-1:0] ref_word;
  logic              have_ref;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_word  <= '0;
      have_ref  <= 1'b0;
      seq_error <= 1'b0;
    end else if (accept) begin
      ref_word <= data_2;
      have_ref <= 1'b1;
      if (have_ref && (data_2 != ref_word + DATA_W'(1))) seq_error <= 1'b1;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign seq_error     = 1'b0;
`endif

endmodule

// File: tb/tb_wrapper_frame_sink.sv
// Directed self-checking bench for wrapper_frame_sink (default build and SUM_W=16 variant).
module tb_wrapper_frame_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        data_2_valid = 1'b0;
  logic [15:0] data_2 = '0;
  logic        buffer_empty = 1'b0;
  logic        frame_ack = 1'b0;

  logic        frame_ready, w_ready;
  logic [23:0] frame_sum;
  logic [15:0] w_sum;
  logic [7:0]  frame_len, w_len;
  logic [15:0] frame_count, drop_count, w_fcount, w_drop;
  logic        seq_error, w_seq;

  int checks   = 0;
  int failures = 0;

`ifdef SINK_SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  wrapper_frame_sink dut (
    .clock(clock), .reset(reset), .data_2_valid(data_2_valid), .data_2(data_2),
    .buffer_empty(buffer_empty), .frame_ack(frame_ack), .frame_ready(frame_ready),
    .frame_sum(frame_sum), .frame_len(frame_len), .frame_count(frame_count),
    .drop_count(drop_count), .seq_error(seq_error)
  );

  wrapper_frame_sink #(.SUM_W(16)) dut_w16 (
    .clock(clock), .reset(reset), .data_2_valid(data_2_valid), .data_2(data_2),
    .buffer_empty(buffer_empty), .frame_ack(frame_ack), .frame_ready(w_ready),
    .frame_sum(w_sum), .frame_len(w_len), .frame_count(w_fcount),
    .drop_count(w_drop), .seq_error(w_seq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    data_2_valid = 1'b1;
    data_2       = w;
    tick();
    data_2_valid = 1'b0;
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  initial begin
    // 1: reset held low while words arrive
    for (int i = 0; i < 4; i++) begin
      data_2_valid = i[0];
      data_2       = 16'(i + 1);
      tick();
      check("rst_ready", {31'd0, frame_ready}, 32'd0);
    end
    data_2_valid = 1'b0;
    check("rst_sum", {8'd0, frame_sum}, 32'd0);
    check("rst_len", {24'd0, frame_len}, 32'd0);
    check("rst_fcount", {16'd0, frame_count}, 32'd0);
    check("rst_drop", {16'd0, drop_count}, 32'd0);
    check("rst_seq", {31'd0, seq_error}, 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, frame_ready}, 32'd0);

    // 2: full frame 1..8, ack on the third HOLD cycle
    for (int i = 1; i <= 7; i++) send_word(16'(i));
    check("full_not_yet", {31'd0, frame_ready}, 32'd0);
    send_word(16'd8);
    check("full_ready1", {31'd0, frame_ready}, 32'd1);
    check("full_sum", {8'd0, frame_sum}, 32'd36);
    check("full_len", {24'd0, frame_len}, 32'd8);
    tick();
    check("full_ready2", {31'd0, frame_ready}, 32'd1);
    tick();
    check("full_ready3", {31'd0, frame_ready}, 32'd1);
    ack_frame();
    check("full_ready_off", {31'd0, frame_ready}, 32'd0);
    check("full_fcount", {16'd0, frame_count}, 32'd1);

    // 3a: timeout after 16 empty cycles
    send_word(16'd5); send_word(16'd6); send_word(16'd7);
    buffer_empty = 1'b1;
    repeat (15) tick();
    check("tmo_15_no_frame", {31'd0, frame_ready}, 32'd0);
    tick();
    check("tmo_ready", {31'd0, frame_ready}, 32'd1);
    check("tmo_sum", {8'd0, frame_sum}, 32'd18);
    check("tmo_len", {24'd0, frame_len}, 32'd3);
    ack_frame();
    buffer_empty = 1'b0;
    check("tmo_fcount", {16'd0, frame_count}, 32'd2);

    // 3b: 15 empty cycles twice, broken by a non-empty cycle -> no timeout
    send_word(16'd5); send_word(16'd6); send_word(16'd7);
    buffer_empty = 1'b1;
    repeat (15) tick();
    check("tmo15a", {31'd0, frame_ready}, 32'd0);
    buffer_empty = 1'b0;
    tick();
    buffer_empty = 1'b1;
    repeat (15) tick();
    check("tmo15b", {31'd0, frame_ready}, 32'd0);
    buffer_empty = 1'b0;
    for (int i = 1; i <= 5; i++) send_word(16'(i));
    check("tmo15_full_ready", {31'd0, frame_ready}, 32'd1);
    check("tmo15_full_sum", {8'd0, frame_sum}, 32'd33);
    check("tmo15_full_len", {24'd0, frame_len}, 32'd8);
    ack_frame();
    check("tmo15_fcount", {16'd0, frame_count}, 32'd3);

    // ack outside HOLD is ignored
    ack_frame();
    check("ack_idle_fcount", {16'd0, frame_count}, 32'd3);
    check("ack_idle_ready", {31'd0, frame_ready}, 32'd0);

    // 4: drops while holding, then word+ack in the same cycle
    for (int i = 1; i <= 8; i++) send_word(16'(i));
    for (int i = 10; i <= 13; i++) send_word(16'(i));
    check("drop_count4", {16'd0, drop_count}, 32'd4);
    check("drop_sum_kept", {8'd0, frame_sum}, 32'd36);
    check("drop_still_ready", {31'd0, frame_ready}, 32'd1);
    frame_ack = 1'b1;
    send_word(16'd14);
    frame_ack = 1'b0;
    check("drop_count5", {16'd0, drop_count}, 32'd5);
    check("drop_ack_ready", {31'd0, frame_ready}, 32'd0);
    check("drop_fcount", {16'd0, frame_count}, 32'd4);
    for (int i = 0; i < 8; i++) send_word(16'(100 + i));
    check("next_frame_sum", {8'd0, frame_sum}, 32'd828);
    check("next_frame_len", {24'd0, frame_len}, 32'd8);
    ack_frame();
    check("next_fcount", {16'd0, frame_count}, 32'd5);

    // 5: all-ones words, 24-bit and 16-bit sums
    for (int i = 0; i < 8; i++) send_word(16'hFFFF);
    check("wrap_sum24", {8'd0, frame_sum}, 32'h0007FFF8);
    check("wrap_ready16", {31'd0, w_ready}, 32'd1);
    check("wrap_sum16", {16'd0, w_sum}, 32'h0000FFF8);
    check("wrap_drop16", {16'd0, w_drop}, 32'd5);
    ack_frame();
    check("wrap_fcount16", {16'd0, w_fcount}, 32'd6);

    // async reset mid-frame discards the partial frame
    send_word(16'd50); send_word(16'd51); send_word(16'd52);
    reset = 1'b0;
    #1;
    check("arst_fcount", {16'd0, frame_count}, 32'd0);
    check("arst_drop", {16'd0, drop_count}, 32'd0);
    check("arst_seq", {31'd0, seq_error}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // 6: sequence 1,2,3,5 then continue the frame
    send_word(16'd1); send_word(16'd2); send_word(16'd3);
    check("seq_ok", {31'd0, seq_error}, 32'd0);
    send_word(16'd5);
    check("seq_err_set", {31'd0, seq_error}, {31'd0, SEQ_ON});
    send_word(16'd6);
    check("seq_err_sticky", {31'd0, seq_error}, {31'd0, SEQ_ON});
    check("seq16_err", {31'd0, w_seq}, {31'd0, SEQ_ON});
    send_word(16'd7); send_word(16'd8);
    check("arst_partial_gone", {31'd0, frame_ready}, 32'd0);
    send_word(16'd9);
    check("arst_frame_sum", {8'd0, frame_sum}, 32'd41);
    check("arst_frame_len", {24'd0, frame_len}, 32'd8);
    ack_frame();
    check("seq_err_after_ack", {31'd0, seq_error}, {31'd0, SEQ_ON});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
